// File: rtl/sprite_plot_scheduler_pkg.sv
// Shared types and constants for the sprite plot scheduler.
package vga_sched_pkg;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int MAX_SPR = 8;

    localparam logic [C_W-1:0] BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ERASE = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Lowest set bit of a sprite mask; 0 when the mask is empty.
    function automatic logic [2:0] first_set(input logic [MAX_SPR-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_SPR - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAX_SPR-1:0] above_mask(input logic [2:0] s);
        return ~((8'd2 << s) - 8'd1);
    endfunction

endpackage

// File: rtl/sprite_plot_scheduler_if.sv
// Pixel write port between the scheduler (master) and the VGA adapter (slave).
interface sprite_plot_scheduler_if;
    import vga_sched_pkg::*;

    logic           plot;
    logic           plot_ready;
    logic [X_W-1:0] plot_x;
    logic [Y_W-1:0] plot_y;
    logic [C_W-1:0] plot_colour;

    modport master (output plot, plot_x, plot_y, plot_colour, input plot_ready);
    modport slave  (input plot, plot_x, plot_y, plot_colour, output plot_ready);

endinterface

// File: rtl/sprite_plot_scheduler_tick.sv
// Free-running frame divider: tick is high for one cycle each time the count wraps to 0.
module frame_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == LAST);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Shares one VGA plot port among N box sprites: per frame tick, erase old boxes then draw new ones.
// Optional build macro SPRITE_SKIP_STATIC_EN skips sprites whose position and colour did not change.
//   state | meaning
//   IDLE  | waiting for frame tick
//   LOAD  | snapshot sprite inputs, pick first sprite
//   ERASE | black boxes at old positions
//   DRAW  | coloured boxes at new positions
//   DONE  | frame_done pulse, new becomes old
module sprite_plot_scheduler
    import vga_sched_pkg::*;
#(
    parameter int N_SPR    = 2,
    parameter int BOX_LOG2 = 2,
    parameter int TICK_DIV = 12500000
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [X_W*N_SPR-1:0]   spr_x,
    input  logic [Y_W*N_SPR-1:0]   spr_y,
    input  logic [C_W*N_SPR-1:0]   spr_colour,
    input  logic [N_SPR-1:0]       spr_en,
    sprite_plot_scheduler_if.master pif,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int PW = 2 * BOX_LOG2;
    localparam logic [PW-1:0] P_LAST = '1;

    logic tick;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    // Inputs widened to MAX_SPR so the 3-bit sprite index never runs off an array.
    logic [X_W*MAX_SPR-1:0] spr_x_pad;
    logic [Y_W*MAX_SPR-1:0] spr_y_pad;
    logic [C_W*MAX_SPR-1:0] spr_c_pad;
    logic [MAX_SPR-1:0]     spr_en_pad;

    assign spr_x_pad  = (X_W*MAX_SPR)'(spr_x);
    assign spr_y_pad  = (Y_W*MAX_SPR)'(spr_y);
    assign spr_c_pad  = (C_W*MAX_SPR)'(spr_colour);
    assign spr_en_pad = MAX_SPR'(spr_en);

    state_t             state_q, state_d;
    logic [2:0]         s_q, s_d;
    logic [PW-1:0]      p_q, p_d;
    logic [MAX_SPR-1:0] erase_m_q, erase_m_d, draw_m_q, draw_m_d;
    logic [MAX_SPR-1:0] new_en_q, new_en_d, old_valid_q, old_valid_d;
    logic [MAX_SPR-1:0] static_m, rest_m;
    logic [X_W-1:0]     new_x_q [MAX_SPR], new_x_d [MAX_SPR], old_x_q [MAX_SPR], old_x_d [MAX_SPR];
    logic [Y_W-1:0]     new_y_q [MAX_SPR], new_y_d [MAX_SPR], old_y_q [MAX_SPR], old_y_d [MAX_SPR];
    logic [C_W-1:0]     new_c_q [MAX_SPR], new_c_d [MAX_SPR];
`ifdef SPRITE_SKIP_STATIC_EN
    logic [C_W-1:0]     old_c_q [MAX_SPR], old_c_d [MAX_SPR];
`endif
    logic               plot_q, plot_d, frame_done_q, frame_done_d, overrun_q, overrun_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [C_W-1:0]     col_q, col_d;
    logic               xfer;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        p_d         = p_q;
        erase_m_d   = erase_m_q;
        draw_m_d    = draw_m_q;
        new_en_d    = new_en_q;
        old_valid_d = old_valid_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        new_c_d     = new_c_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
`ifdef SPRITE_SKIP_STATIC_EN
        old_c_d     = old_c_q;
`endif
        static_m    = '0;
        rest_m      = '0;
        overrun_d   = overrun_q | (tick & (state_q != IDLE));
        xfer        = plot_q & pif.plot_ready;

        case (state_q)
            IDLE: if (tick) state_d = LOAD;
            LOAD: begin
                for (int i = 0; i < MAX_SPR; i++) begin
                    new_x_d[i] = spr_x_pad[X_W*i +: X_W];
                    new_y_d[i] = spr_y_pad[Y_W*i +: Y_W];
                    new_c_d[i] = spr_c_pad[C_W*i +: C_W];
                end
                new_en_d = spr_en_pad;
`ifdef SPRITE_SKIP_STATIC_EN
                for (int i = 0; i < MAX_SPR; i++) begin
                    static_m[i] = old_valid_q[i] & spr_en_pad[i] & (old_x_q[i] == new_x_d[i])
                                  & (old_y_q[i] == new_y_d[i]) & (old_c_q[i] == new_c_d[i]);
                end
`endif
                erase_m_d = old_valid_q & ~static_m;
                draw_m_d  = spr_en_pad & ~static_m;
                p_d       = '0;
                if (|erase_m_d) begin
                    state_d = ERASE;
                    s_d     = first_set(erase_m_d);
                end else if (|draw_m_d) begin
                    state_d = DRAW;
                    s_d     = first_set(draw_m_d);
                end else begin
                    state_d = DONE;
                    s_d     = '0;
                end
            end
            ERASE: if (xfer) begin
                if (p_q == P_LAST) begin
                    p_d    = '0;
                    rest_m = erase_m_q & above_mask(s_q);
                    if (|rest_m) begin
                        s_d = first_set(rest_m);
                    end else if (|draw_m_q) begin
                        state_d = DRAW;
                        s_d     = first_set(draw_m_q);
                    end else begin
                        state_d = DONE;
                        s_d     = '0;
                    end
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            DRAW: if (xfer) begin
                if (p_q == P_LAST) begin
                    p_d    = '0;
                    rest_m = draw_m_q & above_mask(s_q);
                    if (|rest_m) begin
                        s_d = first_set(rest_m);
                    end else begin
                        state_d = DONE;
                        s_d     = '0;
                    end
                end else begin
                    p_d = p_q + PW'(1);
                end
            end
            DONE: begin
                old_x_d     = new_x_q;
                old_y_d     = new_y_q;
`ifdef SPRITE_SKIP_STATIC_EN
                old_c_d     = new_c_q;
`endif
                old_valid_d = new_en_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Next pixel is computed from next-state so the port is purely registered.
        frame_done_d = (state_d == DONE);
        plot_d       = (state_d == ERASE) || (state_d == DRAW);
        x_d          = '0;
        y_d          = '0;
        col_d        = '0;
        if (state_d == ERASE) begin
            x_d   = old_x_q[s_d] + X_W'(p_d[BOX_LOG2-1:0]);
            y_d   = old_y_q[s_d] + Y_W'(p_d[PW-1:BOX_LOG2]);
            col_d = BLACK;
        end else if (state_d == DRAW) begin
            x_d   = new_x_d[s_d] + X_W'(p_d[BOX_LOG2-1:0]);
            y_d   = new_y_d[s_d] + Y_W'(p_d[PW-1:BOX_LOG2]);
            col_d = new_c_d[s_d];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            s_q          <= '0;
            p_q          <= '0;
            erase_m_q    <= '0;
            draw_m_q     <= '0;
            new_en_q     <= '0;
            old_valid_q  <= '0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < MAX_SPR; i++) begin
                new_x_q[i] <= '0;
                new_y_q[i] <= '0;
                new_c_q[i] <= '0;
                old_x_q[i] <= '0;
                old_y_q[i] <= '0;
`ifdef SPRITE_SKIP_STATIC_EN
                old_c_q[i] <= '0;
`endif
            end
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            p_q          <= p_d;
            erase_m_q    <= erase_m_d;
            draw_m_q     <= draw_m_d;
            new_en_q     <= new_en_d;
            old_valid_q  <= old_valid_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_c_q      <= new_c_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
`ifdef SPRITE_SKIP_STATIC_EN
            old_c_q      <= old_c_d;
`endif
        end
    end

    assign pif.plot        = plot_q;
    assign pif.plot_x      = x_q;
    assign pif.plot_y      = y_q;
    assign pif.plot_colour = col_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = frame_done_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Bench for sprite_plot_scheduler: frame table, random frames vs a pixel-list model, stall/overrun/reset cases.
module tb_sprite_plot_scheduler;

    localparam int TICK_DIV = 64;
    localparam int NPIX     = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] spr_x = '0;
    logic [13:0] spr_y = '0;
    logic [5:0]  spr_colour = '0;
    logic [1:0]  spr_en = '0;
    logic        busy, frame_done, overrun;

    sprite_plot_scheduler_if pif();

    sprite_plot_scheduler #(.N_SPR(2), .BOX_LOG2(2), .TICK_DIV(TICK_DIV)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_colour (spr_colour),
        .spr_en     (spr_en),
        .pif        (pif),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] x;
        logic [13:0] y;
        logic [5:0]  c;
        logic [1:0]  en;
        bit          stall;
        int          npix;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, fd_count = 0, fd_cyc = 0, prev_fd = 0;
    int ready_mode = 0;
    int got_q[$], exp_q[$];
    bit prev_stall = 0;
    int prev_pix = 0;
    bit m_ov[2];
    int m_ox[2], m_oy[2], m_oc[2];
    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pack_pix(input int x, input int y, input int c);
        return (x << 10) | (y << 3) | c;
    endfunction

    always @(posedge clock) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        pif.plot_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       pif.plot_ready = 1'b1;
                1:       pif.plot_ready = 1'($urandom_range(0, 1));
                default: pif.plot_ready = 1'b0;
            endcase
        end
    end

    // Collects transfers, counts frame_done pulses, checks stability while stalled.
    initial begin
        int cur;
        forever begin
            @(negedge clock);
            cur = pack_pix(int'(pif.plot_x), int'(pif.plot_y), int'(pif.plot_colour));
            if (!resetn) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_plot", int'(pif.plot), 1);
                    check("hold_pixel", cur, prev_pix);
                end
                if (frame_done) begin
                    fd_count++;
                    fd_cyc = cyc;
                end
                if (pif.plot && pif.plot_ready) got_q.push_back(cur);
                prev_stall = pif.plot && !pif.plot_ready;
                prev_pix   = cur;
            end
        end
    end

    // Expected pixel list from the current sprite inputs and the model's old boxes.
    task automatic build_exp();
        bit skip[2];
        int nx, ny, nc;
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            nx = int'(spr_x[8*s +: 8]);
            ny = int'(spr_y[7*s +: 7]);
            nc = int'(spr_colour[3*s +: 3]);
            skip[s] = 0;
`ifdef SPRITE_SKIP_STATIC_EN
            skip[s] = m_ov[s] && spr_en[s] && nx == m_ox[s] && ny == m_oy[s] && nc == m_oc[s];
`endif
        end
        for (int s = 0; s < 2; s++)
            if (m_ov[s] && !skip[s])
                for (int p = 0; p < NPIX; p++)
                    exp_q.push_back(pack_pix((m_ox[s] + p % 4) % 256, (m_oy[s] + p / 4) % 128, 0));
        for (int s = 0; s < 2; s++) begin
            nx = int'(spr_x[8*s +: 8]);
            ny = int'(spr_y[7*s +: 7]);
            nc = int'(spr_colour[3*s +: 3]);
            if (spr_en[s] && !skip[s])
                for (int p = 0; p < NPIX; p++)
                    exp_q.push_back(pack_pix((nx + p % 4) % 256, (ny + p / 4) % 128, nc));
            m_ov[s] = spr_en[s];
            m_ox[s] = nx;
            m_oy[s] = ny;
            m_oc[s] = nc;
        end
    endtask

    task automatic wait_frame(input int limit);
        int start = fd_count;
        int k = 0;
        while (fd_count == start && k < limit) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("frame_seen", int'(fd_count != start), 1);
    endtask

    task automatic compare_pixels(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_pixel"}, got_q[i], exp_q[i]);
    endtask

    task automatic wait_got(input int n, input int limit);
        int k = 0;
        while (got_q.size() < n && k < limit) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("pixels_reached", int'(got_q.size() >= n), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_plot"}, int'(pif.plot), 0);
        check({name, "_x"}, int'(pif.plot_x), 0);
        check({name, "_y"}, int'(pif.plot_y), 0);
        check({name, "_col"}, int'(pif.plot_colour), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_fd"}, int'(frame_done), 0);
        check({name, "_ovr"}, int'(overrun), 0);
    endtask

    initial begin
        int start;
        // x/y/c are {sprite1, sprite0}
        vecs[0] = '{{8'd0,   8'd10 }, {7'd0,   7'd20 }, {3'd0, 3'd5}, 2'b01, 1'b0, 16};
        vecs[1] = '{{8'd0,   8'd11 }, {7'd0,   7'd20 }, {3'd0, 3'd5}, 2'b01, 1'b0, 32};
        vecs[2] = '{{8'd0,   8'd254}, {7'd0,   7'd126}, {3'd0, 3'd3}, 2'b01, 1'b0, 32};
        vecs[3] = '{{8'd50,  8'd254}, {7'd60,  7'd126}, {3'd6, 3'd3}, 2'b10, 1'b0, 32};
        vecs[4] = '{{8'd50,  8'd100}, {7'd60,  7'd10 }, {3'd6, 3'd1}, 2'b11, 1'b0, 48};
        vecs[5] = '{{8'd50,  8'd100}, {7'd60,  7'd10 }, {3'd6, 3'd1}, 2'b00, 1'b0, 32};
        vecs[6] = '{{8'd50,  8'd100}, {7'd60,  7'd10 }, {3'd6, 3'd1}, 2'b00, 1'b0, 0};
        vecs[7] = '{{8'd255, 8'd100}, {7'd127, 7'd10 }, {3'd7, 3'd1}, 2'b10, 1'b0, 16};
        vecs[8] = '{{8'd255, 8'd11 }, {7'd127, 7'd20 }, {3'd7, 3'd5}, 2'b01, 1'b1, 32};
        for (int s = 0; s < 2; s++) begin
            m_ov[s] = 0; m_ox[s] = 0; m_oy[s] = 0; m_oc[s] = 0;
        end

        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        prev_fd = 0;

        for (int i = 0; i < 9; i++) begin
            spr_x = vecs[i].x; spr_y = vecs[i].y; spr_colour = vecs[i].c; spr_en = vecs[i].en;
            ready_mode = vecs[i].stall ? 1 : 0;
            if (i == 8) check("overrun_clear", int'(overrun), 0);
            build_exp();
            got_q.delete();
            wait_frame(1000);
            check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].npix);
            compare_pixels($sformatf("vec%0d", i));
            if (!vecs[i].stall)
                check($sformatf("vec%0d_len", i), fd_cyc - (prev_fd / TICK_DIV + 1) * TICK_DIV,
                      2 + vecs[i].npix);
            prev_fd = fd_cyc;
        end

        for (int r = 0; r < 6; r++) begin
            spr_x = 16'($urandom); spr_y = 14'($urandom); spr_colour = 6'($urandom);
            spr_en = 2'($urandom_range(0, 3));
            ready_mode = 1;
            build_exp();
            got_q.delete();
            wait_frame(1000);
            compare_pixels($sformatf("rand%0d", r));
            prev_fd = fd_cyc;
        end

        // Reset while drawing: outputs clear next cycle, following frame has no erase.
        ready_mode = 0;
        spr_x = {8'd0, 8'd30}; spr_y = {7'd0, 7'd40}; spr_colour = {3'd0, 3'd2}; spr_en = 2'b01;
        build_exp();
        got_q.delete();
        wait_frame(1000);
        compare_pixels("pre_rst");
        spr_x = {8'd0, 8'd31};
        build_exp();
        got_q.delete();
        wait_got(18, 300);
        resetn = 1'b0;
        @(negedge clock);
        #1;
        check_reset_outputs("mid_draw_rst");
        @(negedge clock);
        #1;
        resetn = 1'b1;
        got_q.delete();
        for (int s = 0; s < 2; s++) m_ov[s] = 0;
        prev_fd = 0;
        build_exp();
        wait_frame(1000);
        compare_pixels("post_rst");
        check("post_rst_len", fd_cyc - TICK_DIV, 18);

        // Long stall spanning a tick: overrun sets, the extra tick is dropped.
        spr_x = {8'd0, 8'd32};
        build_exp();
        got_q.delete();
        start = fd_count;
        wait_got(3, 300);
        ready_mode = 2;
        repeat (100) @(negedge clock);
        #1;
        check("overrun_set", int'(overrun), 1);
        check("no_done_while_stalled", fd_count - start, 0);
        ready_mode = 0;
        wait_frame(1000);
        compare_pixels("ovr_frame");
        check("ovr_one_done", fd_count - start, 1);
        @(negedge clock);
        #1;
        check("ovr_idle_after", int'(busy), 0);
        check("ovr_sticky", int'(overrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 remaining", 1);
        $fatal(1, "watchdog");
    end

endmodule
